inst_fetcher: RTL
=================

# inst_fetcher

Front-end fetch stage that owns the program counter, looks up instructions in a small direct-mapped instruction cache, and refills misses from the memory controller. Every fetched word is presented combinationally to `br_predictor` for next-PC prediction. Each instruction is then handed to the issuer together with its predicted next PC. A flush from the reorder-buffer bus redirects fetch to the correct target.

## Interface

**Parameters**
- `ICACHE_LINES`, default 16: number of one-word cache lines (power of two). Index is `pc[log2(ICACHE_LINES)+1:2]`; tag is the remaining upper PC bits.
- `RESET_PC`, default 32'h0: PC value loaded on reset.

**Ports**
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rdy` input 1: global enable. When low, all state freezes and outputs hold.
- `valid_to_mem_ctrl` output 1: fetch request to the memory controller, held until it is answered.
- `addr_to_mem_ctrl` output 32: word address of the request.
- `valid_from_mem_ctrl` input 1: one-cycle response strobe.
- `inst_from_mem_ctrl` input 32: returned instruction word.
- `inst_to_br_predictor` output 32: cached word at the current PC (combinational).
- `pc_to_br_predictor` output 32: current PC.
- `next_pc_from_br_predictor` input 32: predicted successor of the current PC.
- `valid_to_issuer` output 1: one-cycle pulse per fetched instruction.
- `inst_to_issuer` output 32: fetched instruction.
- `pc_to_issuer` output 32: PC of that instruction.
- `predicted_pc_to_issuer` output 32: predicted next PC, forwarded for ROB verification.
- `full_from_issuer` input 1: issuer cannot accept an instruction this cycle.
- `flush_from_rob_bus` input 1: mispredict or exception redirect.
- `target_pc_from_rob_bus` input 32: redirect target.

## Operation

**States**
- `IDLE`: lookup.
- `WAIT_MEM`: refill outstanding.

**Registers**
- `pc`, `state`, `miss_addr`.
- Per cache line: `valid`, `tag`, `data`.
- Registered issuer outputs and `valid_to_mem_ctrl`.

**Reset** (asynchronous, immediate):
- `pc=RESET_PC`, `state=IDLE`, all line `valid=0`.
- `valid_to_issuer=0`, `valid_to_mem_ctrl=0`.
- `addr_to_mem_ctrl=0`, `inst_to_issuer=0`, `pc_to_issuer=0`, `predicted_pc_to_issuer=0`.

**Hit:** `IDLE`, `valid[idx]` set and `tag[idx]` matches.
- Cache data drives `inst_to_br_predictor`; it is 32'h0 on a miss.

**Per-edge priority** (all cases require `rdy=1`)
1. `flush_from_rob_bus=1`:
   - `pc<=target_pc_from_rob_bus`, `valid_to_issuer<=0`.
   - `IDLE` stays `IDLE`.
   - `WAIT_MEM` stays `WAIT_MEM`; the outstanding request cannot be cancelled. If `valid_from_mem_ctrl` arrives the same cycle, the refill is still performed and the state goes to `IDLE`.
2. `IDLE`, hit, `!full_from_issuer`:
   - `valid_to_issuer<=1`, `inst_to_issuer<=data`, `pc_to_issuer<=pc`, `predicted_pc_to_issuer<=next_pc_from_br_predictor`.
   - `pc<=next_pc_from_br_predictor`.
3. `IDLE`, hit, `full_from_issuer`: `valid_to_issuer<=0`, `pc` held.
4. `IDLE`, miss:
   - `valid_to_issuer<=0`, `miss_addr<=pc`.
   - `valid_to_mem_ctrl<=1`, `addr_to_mem_ctrl<=pc`, state `WAIT_MEM`.
5. `WAIT_MEM`, `valid_from_mem_ctrl`:
   - Write line `idx(miss_addr)`: valid=1, tag, data = `inst_from_mem_ctrl`.
   - `valid_to_mem_ctrl<=0`, state `IDLE`.
   - The refill always uses `miss_addr` and never `pc`, so a refill that follows a flush is harmless.
6. `WAIT_MEM` otherwise: hold everything; `valid_to_issuer=0`.

**Other rules**
- A refill overwrites the line unconditionally; there is no replacement policy.
- PC arithmetic is modulo 2^32.
- Only word-aligned PCs are fetched; `pc[1:0]` is ignored for index and tag.

## Timing

- Hit: instruction is visible at the issuer one cycle after lookup. Throughput is one instruction per cycle while hits continue and `full_from_issuer=0`.
- Miss detected in cycle t: `valid_to_mem_ctrl` is high from t+1 until the edge after the response cycle r.
  - The line is written at the end of r.
  - Lookup hits in r+1, and `valid_to_issuer` pulses in r+2.
  - Minimum miss penalty is 2 cycles beyond memory latency.
- Flush in cycle t: no instruction from the old path is issued after the edge ending t. The first target-path lookup happens in t+1 (state `IDLE`), or after the drained response otherwise.
- `rdy=0`: no state change and no strobe consumption. `valid_from_mem_ctrl` is not expected while `rdy=0`.

## Test plan

1. **Cold start.** Reset with `RESET_PC=0`; memory returns 32'h00000013 at address 0 with 3-cycle latency.
   - Required: `addr_to_mem_ctrl=0` asserted at cycle 1.
   - Required: `valid_to_issuer` pulses with `pc_to_issuer=0`, `inst_to_issuer=32'h00000013`, `predicted_pc_to_issuer=4`.
2. **Hot loop.** Preload addresses 0..12; the predictor returns pc+4 and then a jump to 0 at pc=12.
   - Required: four consecutive pulses with pc 0, 4, 8, 12, then 0 again, with no memory request.
3. **Backpressure.** Hold `full_from_issuer=1` for 3 cycles in the middle of a hit stream.
   - Required: no pulses, `pc` frozen, and the stream resumes at the same pc with no loss or duplication.
4. **Flush during refill.** Miss at 32'h40, then flush to 32'h100 one cycle later.
   - Required: the line for 32'h40 is filled on response, then a request for 32'h100 is issued.
   - Required: no instruction with pc 32'h40 reaches the issuer.
5. **Conflict and rdy stall.** Fetch 32'h0, then 32'h40 (same index with 16 lines), then 32'h0 again.
   - Required: three memory requests.
   - Required: dropping `rdy` for 2 cycles mid-`WAIT_MEM` stretches the sequence by exactly 2 cycles.
6. **Asynchronous reset mid-refill.** Assert `rst` between clock edges while in `WAIT_MEM`.
   - Required: `valid_to_mem_ctrl=0` immediately, all lines invalid, `pc=RESET_PC`.

Source files
------------

// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch stage that owns the program counter. It holds a small
// direct-mapped instruction cache of one-word lines and refills misses from
// the memory controller. Each hit is handed to the issuer together with the
// branch predictor's guess for the next PC. A reorder-buffer flush redirects
// fetch, but it cannot cancel a refill that is already outstanding.

module inst_fetcher #(
  parameter int unsigned ICACHE_LINES = 16,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,

  output logic        valid_to_mem_ctrl,
  output logic [31:0] addr_to_mem_ctrl,
  input  logic        valid_from_mem_ctrl,
  input  logic [31:0] inst_from_mem_ctrl,

  output logic [31:0] inst_to_br_predictor,
  output logic [31:0] pc_to_br_predictor,
  input  logic [31:0] next_pc_from_br_predictor,

  output logic        valid_to_issuer,
  output logic [31:0] inst_to_issuer,
  output logic [31:0] pc_to_issuer,
  output logic [31:0] predicted_pc_to_issuer,
  input  logic        full_from_issuer,

  input  logic        flush_from_rob_bus,
  input  logic [31:0] target_pc_from_rob_bus
);

  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;

  // Only the word address of a miss is kept; the byte offset never selects anything.
  logic [29:0] miss_word;
  logic [29:0] miss_word_next;

  logic        valid_to_mem_ctrl_next;
  logic [31:0] addr_to_mem_ctrl_next;
  logic        valid_to_issuer_next;
  logic [31:0] inst_to_issuer_next;
  logic [31:0] pc_to_issuer_next;
  logic [31:0] predicted_pc_to_issuer_next;

  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
  logic [31:0]             line_data [ICACHE_LINES];

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             hit;
  logic             refill;

  assign pc_idx   = pc[IDX_W+1:2];
  assign pc_tag   = pc[31:IDX_W+2];
  assign miss_idx = miss_word[IDX_W-1:0];
  assign miss_tag = miss_word[29:IDX_W];

  // Cache lookup at the current PC; a line only counts as a hit while no refill is pending.
  always_comb begin
    hit                  = (state == IDLE) && line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
    inst_to_br_predictor = hit ? line_data[pc_idx] : 32'h0;
    pc_to_br_predictor   = pc;
  end

  // Next-state and next-output decision: a flush wins over everything, but an outstanding refill still lands.
  always_comb begin
    state_next                  = state;
    pc_next                     = pc;
    miss_word_next              = miss_word;
    valid_to_mem_ctrl_next      = valid_to_mem_ctrl;
    addr_to_mem_ctrl_next       = addr_to_mem_ctrl;
    valid_to_issuer_next        = 1'b0;
    inst_to_issuer_next         = inst_to_issuer;
    pc_to_issuer_next           = pc_to_issuer;
    predicted_pc_to_issuer_next = predicted_pc_to_issuer;
    refill                      = 1'b0;

    if (flush_from_rob_bus) begin
      pc_next = target_pc_from_rob_bus;
      if ((state == WAIT_MEM) && valid_from_mem_ctrl) begin
        refill                 = 1'b1;
        valid_to_mem_ctrl_next = 1'b0;
        state_next             = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (!full_from_issuer) begin
              valid_to_issuer_next        = 1'b1;
              inst_to_issuer_next         = line_data[pc_idx];
              pc_to_issuer_next           = pc;
              predicted_pc_to_issuer_next = next_pc_from_br_predictor;
              pc_next                     = next_pc_from_br_predictor;
            end
          end else begin
            miss_word_next         = pc[31:2];
            valid_to_mem_ctrl_next = 1'b1;
            addr_to_mem_ctrl_next  = pc;
            state_next             = WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (valid_from_mem_ctrl) begin
            refill                 = 1'b1;
            valid_to_mem_ctrl_next = 1'b0;
            state_next             = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Control state, line valid bits and registered outputs; rdy low freezes all of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      pc                     <= RESET_PC;
      miss_word              <= '0;
      line_valid             <= '0;
      valid_to_mem_ctrl      <= 1'b0;
      addr_to_mem_ctrl       <= 32'h0;
      valid_to_issuer        <= 1'b0;
      inst_to_issuer         <= 32'h0;
      pc_to_issuer           <= 32'h0;
      predicted_pc_to_issuer <= 32'h0;
    end else if (rdy) begin
      state                  <= state_next;
      pc                     <= pc_next;
      miss_word              <= miss_word_next;
      valid_to_mem_ctrl      <= valid_to_mem_ctrl_next;
      addr_to_mem_ctrl       <= addr_to_mem_ctrl_next;
      valid_to_issuer        <= valid_to_issuer_next;
      inst_to_issuer         <= inst_to_issuer_next;
      pc_to_issuer           <= pc_to_issuer_next;
      predicted_pc_to_issuer <= predicted_pc_to_issuer_next;
      if (refill) begin
        line_valid[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage needs no reset because the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rdy && refill) begin
      line_tag[miss_idx]  <= miss_tag;
      line_data[miss_idx] <= inst_from_mem_ctrl;
    end
  end

endmodule
